capture_ctrl: RTL and testbench

// Sequencer for the 4096x8 single-port sample buffer. Streams ADC samples into the buffer as a ring,

---
 rtl/capture_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for a single-port sample buffer.
// Streams ADC samples into the buffer as a ring, arms after the pre-trigger fill, captures a
// post-trigger run, then reads the window back out oldest-first over the same port.
module capture_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clka_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pre_len_i,
    input  logic [ADDR_W-1:0] post_len_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic              trig_edge_i,
    input  logic              force_trig_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_valid_i,
    input  logic              rd_next_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [DATA_W-1:0] dia_o,
    output logic              wea_o,
    input  logic [DATA_W-1:0] doa_i
);

    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StArmed,
        StPost,
        StDone,
        StRead
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]   pl_q, pl_d;
    logic [ADDR_W-1:0]   ql_q, ql_d;
    logic [ADDR_W:0]     win_q, win_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_ok_q, prev_ok_d;
    logic                force_seen_q, force_seen_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    // Read pipeline: s1 = address on the port, s2 = doa valid this cycle.
    logic                s1_q, s1_d, s1_last_q, s1_last_d;
    logic                s2_q, s2_d, s2_last_q, s2_last_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dia_q, dia_d;
    logic                wea_q, wea_d;

    logic                begin_cap;
    logic                wr_sample;
    logic                fetch;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [ADDR_W:0]     cnt_base;
    logic [ADDR_W-1:0]   ql_max;
    logic [ADDR_W-1:0]   ql_lat;
    logic                rise_hit;
    logic                fall_hit;
    logic                edge_hit;

    // Post length is clamped so the whole window fits in the ring without self-overwrite.
    assign ql_max = {ADDR_W{1'b1}} - pre_len_i;
    assign ql_lat = (post_len_i < ql_max) ? post_len_i : ql_max;

    assign rise_hit = prev_ok_q && (prev_q < trig_level_i) && (adc_data_i >= trig_level_i);
    assign fall_hit = prev_ok_q && (prev_q > trig_level_i) && (adc_data_i <= trig_level_i);
    assign edge_hit = trig_edge_i ? fall_hit : rise_hit;

    // Next-state, buffer-port and readout pipeline logic.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        pl_d         = pl_q;
        ql_d         = ql_q;
        win_d        = win_q;
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        force_seen_d = force_seen_q;
        trig_addr_d  = trig_addr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        s1_d         = 1'b0;
        s1_last_d    = 1'b0;
        s2_d         = s1_q;
        s2_last_d    = s1_last_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        addra_d      = addra_q;
        dia_d        = dia_q;
        wea_d        = 1'b0;
        begin_cap    = 1'b0;
        wr_sample    = 1'b0;
        fetch        = 1'b0;
        fetch_addr   = rd_ptr_q;
        cnt_base     = rd_cnt_q;

        if (s2_q) begin
            rd_data_d  = doa_i;
            rd_valid_d = 1'b1;
            rd_last_d  = s2_last_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin_cap = 1'b1;
            end
            StFill: begin
                if (adc_valid_i) begin
                    wr_sample  = 1'b1;
                    fill_cnt_d = fill_cnt_q + AddrOne;
                end
                if (fill_cnt_q == pl_q) state_d = StArmed;
            end
            StArmed: begin
                if (force_trig_i) force_seen_d = 1'b1;
                if (adc_valid_i) begin
                    wr_sample = 1'b1;
                    if (edge_hit || force_seen_q || force_trig_i) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = '0;
                        state_d     = StPost;
                    end
                end
            end
            StPost: begin
                // Leave one cycle after the last sample so its write lands while still in POST.
                if (post_cnt_q == ql_q) begin
                    state_d = StDone;
                end else if (adc_valid_i) begin
                    wr_sample  = 1'b1;
                    post_cnt_d = post_cnt_q + AddrOne;
                end
            end
            StDone: begin
                if (start_i) begin
                    begin_cap = 1'b1;
                end else if (rd_next_i) begin
                    state_d    = StRead;
                    fetch      = 1'b1;
                    fetch_addr = trig_addr_q - pl_q;
                    cnt_base   = '0;
                end
            end
            StRead: begin
                if (s2_q && s2_last_q) begin
                    state_d = StDone;
                end else if (rd_next_i && !s1_q && !s2_q && (rd_cnt_q != win_q)) begin
                    fetch = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_sample) begin
            wea_d     = 1'b1;
            addra_d   = wr_ptr_q;
            dia_d     = adc_data_i;
            wr_ptr_d  = wr_ptr_q + AddrOne;
            prev_d    = adc_data_i;
            prev_ok_d = 1'b1;
        end

        if (fetch) begin
            addra_d   = fetch_addr;
            rd_ptr_d  = fetch_addr + AddrOne;
            rd_cnt_d  = cnt_base + CntOne;
            s1_d      = 1'b1;
            s1_last_d = ((cnt_base + CntOne) == win_q);
        end

        if (begin_cap) begin
            state_d      = StFill;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            prev_ok_d    = 1'b0;
            force_seen_d = 1'b0;
            pl_d         = pre_len_i;
            ql_d         = ql_lat;
            win_d        = {1'b0, pre_len_i} + {1'b0, ql_lat} + CntOne;
        end

        // Abort flushes any in-flight fetch so no stale rd_valid escapes.
        if (abort_i) begin
            state_d    = StIdle;
            wea_d      = 1'b0;
            s1_d       = 1'b0;
            s2_d       = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_data_d  = rd_data_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clka_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            pl_q         <= '0;
            ql_q         <= '0;
            win_q        <= '0;
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            force_seen_q <= 1'b0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            s1_q         <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_q         <= 1'b0;
            s2_last_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            addra_q      <= '0;
            dia_q        <= '0;
            wea_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pl_q         <= pl_d;
            ql_q         <= ql_d;
            win_q        <= win_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            force_seen_q <= force_seen_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            s1_q         <= s1_d;
            s1_last_q    <= s1_last_d;
            s2_q         <= s2_d;
            s2_last_q    <= s2_last_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            addra_q      <= addra_d;
            dia_q        <= dia_d;
            wea_q        <= wea_d;
        end
    end

    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = (state_q == StDone) || (state_q == StRead);
    assign trig_addr_o = trig_addr_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign addra_o     = addra_q;
    assign dia_o       = dia_q;
    assign wea_o       = wea_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural 4096x8 single-port buffer.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, trig_edge, force_trig, adc_valid, rd_next;
    logic [11:0] pre_len, post_len;
    logic [7:0]  trig_level, adc_data;
    logic [7:0]  rd_data, dia, doa;
    logic        rd_valid, rd_last, busy, done, wea;
    logic [11:0] trig_addr, addra;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_win[$];
    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    // Buffer model: registered read, doa valid the cycle after addra.
    always @(posedge clk) begin
        if (wea) mem[addra] <= dia;
        doa <= mem[addra];
    end

    capture_ctrl #(.ADDR_W(12), .DATA_W(8)) dut (
        .clka_i      (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .pre_len_i   (pre_len),
        .post_len_i  (post_len),
        .trig_level_i(trig_level),
        .trig_edge_i (trig_edge),
        .force_trig_i(force_trig),
        .adc_data_i  (adc_data),
        .adc_valid_i (adc_valid),
        .rd_next_i   (rd_next),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .rd_last_o   (rd_last),
        .busy_o      (busy),
        .done_o      (done),
        .trig_addr_o (trig_addr),
        .addra_o     (addra),
        .dia_o       (dia),
        .wea_o       (wea),
        .doa_i       (doa)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d, input logic f);
        adc_valid  = 1'b1;
        adc_data   = d;
        force_trig = f;
        step();
        adc_valid  = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic start_cap(input logic [11:0] pl, input logic [11:0] ql,
                             input logic [7:0] lvl, input logic edg);
        pre_len    = pl;
        post_len   = ql;
        trig_level = lvl;
        trig_edge  = edg;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic read_window(input string name, input int n, input logic [11:0] addr0);
        int bad_d, bad_a, bad_l, got, fk;
        logic [7:0]  fgot, fexp;
        logic [11:0] a;
        logic        seen;
        bad_d = 0; bad_a = 0; bad_l = 0; got = 0; fk = -1; fgot = '0; fexp = '0;
        for (int k = 0; k < n; k++) begin
            rd_next = 1'b1;
            step();
            rd_next = 1'b0;
            a = addr0 + 12'(k);
            if (addra !== a) bad_a++;
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                step();
                if (rd_valid === 1'b1) seen = 1'b1;
            end
            if (!seen) break;
            got++;
            if (rd_data !== exp_win[k]) begin
                if (fk < 0) begin fk = k; fgot = rd_data; fexp = exp_win[k]; end
                bad_d++;
            end
            if (rd_last !== (k == n - 1)) bad_l++;
        end
        total++;
        if (got !== n) begin
            bad++;
            $display("FAIL %s_count: got %0d samples, expected %0d", name, got, n);
        end
        total++;
        if (bad_d !== 0) begin
            bad++;
            $display("FAIL %s_data: %0d wrong, first at %0d got %h expected %h",
                     name, bad_d, fk, fgot, fexp);
        end
        total++;
        if (bad_a !== 0) begin
            bad++;
            $display("FAIL %s_addr: %0d fetch addresses wrong, expected from %0d",
                     name, bad_a, addr0);
        end
        total++;
        if (bad_l !== 0) begin
            bad++;
            $display("FAIL %s_last: %0d rd_last errors, expected only on sample %0d",
                     name, bad_l, n);
        end
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL %s_done_after: done/busy got %b expected 10", name, {done, busy});
        end
    endtask

    task automatic test_reset();
        total++;
        if ({rd_data, rd_valid, rd_last, busy, done, trig_addr, addra, dia, wea} !== 45'd0) begin
            bad++;
            $display("FAIL reset: outputs got %h expected 0",
                     {rd_data, rd_valid, rd_last, busy, done, trig_addr, addra, dia, wea});
        end
    endtask

    task automatic test_rising();
        start_cap(12'd4, 12'd3, 8'h80, 1'b0);
        for (int i = 0; i < 11; i++) begin
            feed(8'(16 * (i + 1)), 1'b0);
            if (i == 0) begin
                total++;
                if ({wea, addra, dia} !== {1'b1, 12'd0, 8'h10}) begin
                    bad++;
                    $display("FAIL rise_write: wea/addra/dia got %h expected %h",
                             {wea, addra, dia}, {1'b1, 12'd0, 8'h10});
                end
            end
        end
        step();
        step();
        total++;
        if (trig_addr !== 12'd7) begin
            bad++;
            $display("FAIL rise_trig_addr: got %0d expected 7", trig_addr);
        end
        total++;
        if ({done, busy, wea} !== 3'b100) begin
            bad++;
            $display("FAIL rise_done: done/busy/wea got %b expected 100", {done, busy, wea});
        end
        exp_win.delete();
        for (int k = 0; k < 8; k++) exp_win.push_back(8'(16 * (k + 4)));
        read_window("rise", 8, 12'd3);
    endtask

    task automatic test_wrap();
        start_cap(12'd8, 12'd4, 8'h80, 1'b0);
        for (int i = 0; i < 5000; i++) feed(8'(i % 128), 1'b0);
        for (int j = 0; j < 5; j++) feed(8'(8'hC0 + j), 1'b0);
        step();
        step();
        total++;
        if (trig_addr !== 12'd904) begin
            bad++;
            $display("FAIL wrap_trig_addr: got %0d expected 904", trig_addr);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done: got %b expected 1", done);
        end
        exp_win.delete();
        for (int k = 0; k < 8; k++) exp_win.push_back(8'(k));
        for (int j = 0; j < 5; j++) exp_win.push_back(8'(8'hC0 + j));
        read_window("wrap", 13, 12'd896);
    endtask

    task automatic test_clamp();
        // Level 0 with rising edge can never fire, so only the force pulse triggers.
        start_cap(12'd4000, 12'd4000, 8'h00, 1'b0);
        for (int i = 0; i < 4200; i++) feed(8'(i % 256), i == 4100);
        step();
        total++;
        if ({done, trig_addr} !== {1'b1, 12'd4}) begin
            bad++;
            $display("FAIL clamp_trig: done/trig_addr got %h expected %h",
                     {done, trig_addr}, {1'b1, 12'd4});
        end
        exp_win.delete();
        for (int idx = 100; idx < 4196; idx++) exp_win.push_back(8'(idx % 256));
        read_window("clamp", 4096, 12'd100);
    endtask

    task automatic test_force_falling();
        start_cap(12'd2, 12'd2, 8'h80, 1'b1);
        for (int i = 0; i < 10; i++) feed(8'h20, 1'b0);
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL force_armed: busy/done got %b expected 10", {busy, done});
        end
        feed(8'h20, 1'b0);
        feed(8'h20, 1'b0);
        step();
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL force_post_mid: busy/done got %b expected 10", {busy, done});
        end
        feed(8'h20, 1'b0);
        step();
        step();
        total++;
        if ({done, busy, trig_addr} !== {2'b10, 12'd10}) begin
            bad++;
            $display("FAIL force_done: done/busy/trig_addr got %h expected %h",
                     {done, busy, trig_addr}, {2'b10, 12'd10});
        end
    endtask

    task automatic test_handshake();
        int cnt, first;
        logic [7:0] d;
        logic l;
        cnt = 0; first = 0; d = '0; l = 1'b0;
        rd_next = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rd_valid === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
                d = rd_data;
                l = rd_last;
            end
            if (k == 3) rd_next = 1'b0;
        end
        total++;
        if (cnt !== 1) begin
            bad++;
            $display("FAIL hs_count: got %0d rd_valid pulses expected 1", cnt);
        end
        total++;
        if (first !== 3) begin
            bad++;
            $display("FAIL hs_latency: rd_valid at cycle %0d expected 3", first);
        end
        total++;
        if ({d, l} !== {8'h20, 1'b0}) begin
            bad++;
            $display("FAIL hs_data: data/last got %h expected %h", {d, l}, {8'h20, 1'b0});
        end
        total++;
        if ({busy, done} !== 2'b11) begin
            bad++;
            $display("FAIL hs_read_state: busy/done got %b expected 11", {busy, done});
        end
    endtask

    task automatic test_abort();
        int nv;
        nv = 0;
        rd_next = 1'b1;
        step();
        rd_next = 1'b0;
        abort   = 1'b1;
        step();
        abort   = 1'b0;
        if (rd_valid === 1'b1) nv++;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rd_valid === 1'b1) nv++;
        end
        total++;
        if (nv !== 0) begin
            bad++;
            $display("FAIL abort_rd_valid: got %0d pulses expected 0", nv);
        end
        total++;
        if ({busy, done, wea} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle: busy/done/wea got %b expected 000", {busy, done, wea});
        end
    endtask

    task automatic test_reset_mid_post();
        start_cap(12'd1, 12'd50, 8'h80, 1'b0);
        feed(8'h10, 1'b0);
        feed(8'h10, 1'b0);
        feed(8'h10, 1'b0);
        feed(8'h90, 1'b0);
        feed(8'h90, 1'b0);
        total++;
        if ({busy, wea, trig_addr} !== {2'b11, 12'd3}) begin
            bad++;
            $display("FAIL post_before_reset: busy/wea/trig_addr got %h expected %h",
                     {busy, wea, trig_addr}, {2'b11, 12'd3});
        end
        adc_valid = 1'b1;
        adc_data  = 8'h90;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rd_data, rd_valid, rd_last, busy, done, trig_addr, addra, dia, wea} !== 45'd0) begin
            bad++;
            $display("FAIL reset_mid_post: outputs got %h expected 0",
                     {rd_data, rd_valid, rd_last, busy, done, trig_addr, addra, dia, wea});
        end
        adc_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; trig_edge = 1'b0; force_trig = 1'b0;
        adc_valid = 1'b0; rd_next = 1'b0;
        pre_len = '0; post_len = '0; trig_level = '0; adc_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_rising();
        test_wrap();
        test_clamp();
        test_force_falling();
        test_handshake();
        test_abort();
        test_reset_mid_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
